// File: rtl/rom_arb_pkg.sv
// ============================================================================
// Module      : rom_arb_pkg
// Description : Shared widths, FSM encoding and helpers for rom_read_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

   localparam int c_ADDR_W = 10;
   localparam int c_DATA_W = 10;
   localparam int c_LEN_W  = 4;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_BURST = 2'd1;
   localparam logic [1:0] c_ST_DRAIN = 2'd2;

   // Round-robin pointer moves to the requester that was not just served.
   function automatic logic f_other(input logic i_n);
      return ~i_n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant; pointer only breaks ties.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic [1:0] req,
   input  logic       pointer,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = pointer ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rom_read_arbiter.sv
// ============================================================================
// Module      : rom_read_arbiter
// Description : Arbitrates two burst readers onto one synchronous ROM port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_read_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W,
   parameter int LEN_W  = c_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [LEN_W-1:0]  req0_len,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [LEN_W-1:0]  req1_len,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp0_last,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              rsp1_last,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              busy
);

   logic [1:0]        r_state;
   logic              r_ptr;
   logic              r_owner;
   logic [LEN_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [1:0]        r_rsp_valid;
   logic [1:0]        r_rsp_last;

   logic [1:0]        w_req;
   logic [1:0]        w_grant;
   logic [1:0]        w_ready;
   logic [1:0]        w_hs;
   logic              w_idle;

   assign w_req = {req1_valid, req0_valid};

   rr_arb2 u_rr_arb2 (
      .req     (w_req),
      .pointer (r_ptr),
      .grant   (w_grant)
   );

   assign w_idle  = (r_state == c_ST_IDLE);
   // Gated by rst_n so no requester sees ready while reset is held.
   assign w_ready = (rst_n && w_idle) ? w_grant : 2'b00;
   assign w_hs    = w_ready & w_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_ST_IDLE;
         r_ptr       <= 1'b0;
         r_owner     <= 1'b0;
         r_cnt       <= '0;
         r_rom_addr  <= '0;
         r_rsp_valid <= 2'b00;
         r_rsp_last  <= 2'b00;
      end else begin
         r_rsp_valid <= 2'b00;
         r_rsp_last  <= 2'b00;
         case (r_state)
            c_ST_IDLE: begin
               if (|w_hs) begin
                  r_state    <= c_ST_BURST;
                  r_owner    <= w_hs[1];
                  r_ptr      <= f_other(w_hs[1]);
                  r_rom_addr <= w_hs[1] ? req1_addr : req0_addr;
                  r_cnt      <= w_hs[1] ? req1_len  : req0_len;
               end
            end
            c_ST_BURST: begin
               // ROM data for this address returns next cycle, so flag it now.
               r_rsp_valid[r_owner] <= 1'b1;
               if (r_cnt == '0) begin
                  r_rsp_last[r_owner] <= 1'b1;
                  r_state             <= c_ST_DRAIN;
               end else begin
                  r_rom_addr <= r_rom_addr + ADDR_W'(1);
                  r_cnt      <= r_cnt - LEN_W'(1);
               end
            end
            c_ST_DRAIN: begin
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign req0_ready = w_ready[0];
   assign req1_ready = w_ready[1];

   assign rsp0_valid = r_rsp_valid[0];
   assign rsp1_valid = r_rsp_valid[1];
   assign rsp0_last  = r_rsp_last[0];
   assign rsp1_last  = r_rsp_last[1];
   assign rsp0_data  = r_rsp_valid[0] ? rom_data : '0;
   assign rsp1_data  = r_rsp_valid[1] ? rom_data : '0;

   assign rom_addr = r_rom_addr;
   assign busy     = !w_idle;

endmodule

`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
// ============================================================================
// Module      : tb_rom_read_arbiter
// Description : Directed plus random bench for rom_read_arbiter with a ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_read_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [9:0] req0_addr, req1_addr;
   logic [3:0] req0_len, req1_len;
   logic       rsp0_valid, rsp1_valid, rsp0_last, rsp1_last;
   logic [9:0] rsp0_data, rsp1_data;
   logic [9:0] rom_addr;
   logic [9:0] rom_data;
   logic       busy;

   rom_read_arbiter u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_len   (req0_len),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_len   (req1_len),
      .rsp0_valid (rsp0_valid),
      .rsp0_data  (rsp0_data),
      .rsp0_last  (rsp0_last),
      .rsp1_valid (rsp1_valid),
      .rsp1_data  (rsp1_data),
      .rsp1_last  (rsp1_last),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] mem [0:1023];
   always @(posedge clk) rom_data <= mem[rom_addr];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      int         due;
      logic       own;
      logic [9:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      int         due;
      logic [9:0] addr;
   } addr_t;

   beat_t beat_q[$];
   addr_t addr_q[$];
   beat_t obs_q[$];
   int    grant_log[$];
   int    cyc      = 0;
   int    idle_at  = 0;
   int    busy_cnt = 0;
   logic  m_ptr    = 1'b0;

   // Reference model: each accepted burst is expanded into its expected
   // address and beat timeline at the moment of acceptance.
   initial begin : monitor
      logic       m_idle, e_v, e_own, e_last, hn;
      logic [9:0] e_data;
      logic [1:0] g;
      int         a, l;
      beat_t      e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_rsp0_last", rsp0_last, 0);
            chk("rst_rsp1_last", rsp1_last, 0);
            chk("rst_rsp0_data", rsp0_data, 0);
            chk("rst_rsp1_data", rsp1_data, 0);
            chk("rst_rom_addr", rom_addr, 0);
            beat_q.delete();
            addr_q.delete();
            m_ptr   = 1'b0;
            idle_at = 0;
         end else begin
            m_idle = (cyc >= idle_at);
            if (req0_valid && req1_valid) g = m_ptr ? 2'b10 : 2'b01;
            else                          g = {req1_valid, req0_valid};
            chk("busy", busy, !m_idle);
            chk("ready0", req0_ready, m_idle && g[0]);
            chk("ready1", req1_ready, m_idle && g[1]);
            if (busy) busy_cnt++;

            e_v = (beat_q.size() > 0) && (beat_q[0].due == cyc);
            e_own = 1'b0; e_last = 1'b0; e_data = '0;
            if (e_v) begin
               e = beat_q.pop_front();
               e_own = e.own; e_last = e.last; e_data = e.data;
            end
            chk("rsp0_valid", rsp0_valid, e_v && !e_own);
            chk("rsp1_valid", rsp1_valid, e_v && e_own);
            chk("rsp0_last", rsp0_last, e_v && !e_own && e_last);
            chk("rsp1_last", rsp1_last, e_v && e_own && e_last);
            if (e_v) chk("rsp_data", e_own ? rsp1_data : rsp0_data, e_data);

            if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
               chk("rom_addr", rom_addr, addr_q[0].addr);
               void'(addr_q.pop_front());
            end

            if (rsp0_valid) obs_q.push_back('{cyc, 1'b0, rsp0_data, rsp0_last});
            if (rsp1_valid) obs_q.push_back('{cyc, 1'b1, rsp1_data, rsp1_last});

            if (m_idle && g != 2'b00) begin
               hn = g[1];
               a  = hn ? int'(req1_addr) : int'(req0_addr);
               l  = hn ? int'(req1_len)  : int'(req0_len);
               for (int k = 0; k <= l; k++) begin
                  beat_q.push_back('{cyc + 2 + k, hn, mem[(a + k) % 1024], (k == l)});
                  addr_q.push_back('{cyc + 1 + k, 10'((a + k) % 1024)});
               end
               idle_at = cyc + l + 3;
               m_ptr   = !hn;
               grant_log.push_back(int'(hn));
            end
         end
      end
   end

   logic jit1 = 1'b0;

   task automatic cyc_step();
      logic h0, h1;
      @(negedge clk);
      h0 = req0_valid && req0_ready && rst_n;
      h1 = req1_valid && req1_ready && rst_n;
      @(posedge clk);
      #1;
      if (h0) begin
         req0_valid = 1'b0; req0_addr = 10'($urandom); req0_len = 4'($urandom);
      end
      if (h1) begin
         req1_valid = 1'b0; req1_addr = 10'($urandom); req1_len = 4'($urandom);
      end else if (req1_valid && jit1) begin
         req1_addr = 10'($urandom); req1_len = 4'($urandom);
      end
   endtask

   task automatic issue(input int n, input int a, input int l);
      if (n == 0) begin
         req0_valid = 1'b1; req0_addr = 10'(a); req0_len = 4'(l);
      end else begin
         req1_valid = 1'b1; req1_addr = 10'(a); req1_len = 4'(l);
      end
   endtask

   task automatic drain(input int limit);
      int k;
      k = 0;
      while ((req0_valid || req1_valid || busy) && k < limit) begin
         cyc_step();
         k++;
      end
      chk("drain_bound", k < limit, 1);
      cyc_step();
   endtask

   initial begin : stimulus
      for (int i = 0; i < 1024; i++) mem[i] = 10'($urandom);
      mem[2] = 10'b1010101010;
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_len = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_len = '0;

      // Both requesters valid while in reset.
      issue(0, 5, 1);
      issue(1, 7, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready0", req0_ready, 0);
      chk("reset_ready1", req1_ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rom_addr", rom_addr, 0);
      rst_n = 1'b1;
      drain(100);
      chk("contend_count", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         chk("contend_first", grant_log[0], 0);
         chk("contend_second", grant_log[1], 1);
      end

      // Single beat from address 2.
      obs_q.delete();
      issue(0, 2, 0);
      drain(100);
      chk("single_count", obs_q.size(), 1);
      if (obs_q.size() == 1) begin
         chk("single_data", obs_q[0].data, 10'b1010101010);
         chk("single_last", obs_q[0].last, 1);
         chk("single_owner", obs_q[0].own, 0);
      end

      // Three-beat burst for requester 1.
      obs_q.delete();
      busy_cnt = 0;
      issue(1, 0, 2);
      drain(100);
      chk("burst_busy_cycles", busy_cnt, 4);
      chk("burst_count", obs_q.size(), 3);
      if (obs_q.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            chk("burst_data", obs_q[k].data, mem[k]);
            chk("burst_last", obs_q[k].last, (k == 2));
            chk("burst_owner", obs_q[k].own, 1);
         end
      end

      // Repeated contention alternates.
      grant_log.delete();
      repeat (2) begin
         issue(0, $urandom_range(0, 1023), $urandom_range(0, 15));
         issue(1, $urandom_range(0, 1023), $urandom_range(0, 15));
         drain(200);
      end
      chk("alt_count", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         for (int k = 0; k < 4; k++) chk("alt_order", grant_log[k], k % 2);
      end

      // Address wrap.
      obs_q.delete();
      issue(0, 1022, 3);
      drain(100);
      chk("wrap_count", obs_q.size(), 4);

      // Requester 1 waits during a requester 0 burst with moving inputs.
      issue(0, 100, 5);
      cyc_step();
      cyc_step();
      jit1 = 1'b1;
      issue(1, $urandom_range(0, 1023), $urandom_range(0, 15));
      drain(200);
      jit1 = 1'b0;

      // Reset during a long burst, with requester 1 waiting across reset.
      obs_q.delete();
      issue(0, 50, 15);
      for (int k = 0; k < 40 && obs_q.size() < 5; k++) cyc_step();
      chk("midburst_beats", obs_q.size(), 5);
      rst_n = 1'b0;
      #1;
      chk("async_rsp0_valid", rsp0_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_rom_addr", rom_addr, 0);
      req0_valid = 1'b0;
      issue(1, 300, 1);
      cyc_step();
      cyc_step();
      obs_q.delete();
      rst_n = 1'b1;
      drain(100);
      chk("post_reset_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("post_reset_owner0", obs_q[0].own, 1);
         chk("post_reset_owner1", obs_q[1].own, 1);
      end

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(1, 3);
         jit1 = 1'($urandom_range(0, 1));
         if (r[0]) issue(0, $urandom_range(0, 1023), $urandom_range(0, 15));
         repeat ($urandom_range(0, 3)) cyc_step();
         if (r[1]) issue(1, $urandom_range(0, 1023), $urandom_range(0, 15));
         drain(200);
      end
      jit1 = 1'b0;

      chk("beats_pending", beat_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
